// File: rtl/seq_detect_ctrl.sv
// Runtime-configurable serial pattern detector with match counting and a threshold interrupt.
// Latency: out is combinational on the current valid bit; match_count/irq/busy/cfg_err are registered and update one edge later.
// Backpressure: none, one bit consumed per in_valid cycle in RUN; bits are ignored in IDLE and DONE.
module seq_detect_ctrl #(
    parameter int PAT_MAX = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(PAT_MAX) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_wr,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_thresh,
    input  logic               start,
    input  logic               stop,
    input  logic               in_valid,
    input  logic               in_seq,
    output logic               out,
    output logic [CNT_W-1:0]   match_count,
    output logic               irq,
    output logic               busy,
    output logic               cfg_err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    logic [PAT_MAX-1:0]   pattern_q;
    logic [LEN_W-1:0]     len_q;
    logic                 overlap_q;
    logic [CNT_W-1:0]     thresh_q;
    // Only the len-1 most recent bits are ever compared (the newest comes
    // straight from in_seq), so PAT_MAX-1 stored bits cover the longest pattern.
    logic [PAT_MAX-2:0]   hist;
    logic [LEN_W-1:0]     fill;

    logic [PAT_MAX-1:0]   window;
    logic [PAT_MAX-1:0]   len_mask;
    logic                 fill_ok;
    logic                 cfg_ok;
    logic                 count_sat;
    logic [CNT_W-1:0]     count_next;
    logic                 hit_thresh;
    logic [LEN_W-1:0]     fill_next;

    // Mask of the active pattern bits [len-1:0]
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_MAX; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
    end

    // Mealy match, counter saturation and next-fill decisions
    always_comb begin
        window     = {hist, in_seq};
        fill_ok    = (fill >= (len_q - LEN_W'(1)));
        out        = (state == RUN) && in_valid && fill_ok &&
                     (((window ^ pattern_q) & len_mask) == '0);
        cfg_ok     = (state == IDLE) && (cfg_len >= LEN_W'(2)) &&
                     (cfg_len <= LEN_W'(PAT_MAX));
        count_sat  = (thresh_q != '0) ? (match_count >= thresh_q) : (&match_count);
        count_next = match_count + CNT_W'(1);
        hit_thresh = (thresh_q != '0) && !count_sat && (count_next == thresh_q);
        if (out && !overlap_q) begin
            // Non-overlapping: a match consumes its bits, so restart the fill.
            fill_next = '0;
        end else if (fill == LEN_W'(PAT_MAX)) begin
            fill_next = fill;
        end else begin
            fill_next = fill + LEN_W'(1);
        end
    end

    // Control FSM, config registers and detection state with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pattern_q   <= PAT_MAX'(5'b10110);
            len_q       <= LEN_W'(5);
            overlap_q   <= 1'b1;
            thresh_q    <= '0;
            hist        <= '0;
            fill        <= '0;
            match_count <= '0;
            irq         <= 1'b0;
            busy        <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_err <= cfg_wr && !cfg_ok;
            if (cfg_wr && cfg_ok) begin
                pattern_q <= cfg_pattern;
                len_q     <= cfg_len;
                overlap_q <= cfg_overlap;
                thresh_q  <= cfg_thresh;
            end

            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state       <= RUN;
                        busy        <= 1'b1;
                        hist        <= '0;
                        fill        <= '0;
                        match_count <= '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (start) begin
                        hist        <= '0;
                        fill        <= '0;
                        match_count <= '0;
                    end else if (in_valid) begin
                        hist <= window[PAT_MAX-2:0];
                        fill <= fill_next;
                        if (out && !count_sat) begin
                            match_count <= count_next;
                        end
                        if (out && hit_thresh) begin
                            state <= DONE;
                            irq   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (stop) begin
                        state <= IDLE;
                        irq   <= 1'b0;
                        busy  <= 1'b0;
                    end else if (start) begin
                        state       <= RUN;
                        irq         <= 1'b0;
                        hist        <= '0;
                        fill        <= '0;
                        match_count <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    irq   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: table of per-cycle vectors plus a mid-stream reset sequence.
module tb_seq_detect_ctrl;

    logic       clk;
    logic       rst;
    logic       cfg_wr;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic [7:0] cfg_thresh;
    logic       start;
    logic       stop;
    logic       in_valid;
    logic       in_seq;
    logic       out;
    logic [7:0] match_count;
    logic       irq;
    logic       busy;
    logic       cfg_err;

    int tests;
    int fails;

    seq_detect_ctrl #(.PAT_MAX(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_thresh(cfg_thresh),
        .start(start), .stop(stop), .in_valid(in_valid), .in_seq(in_seq),
        .out(out), .match_count(match_count), .irq(irq), .busy(busy), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs for one cycle; e_out is checked before the edge, the rest after it.
    typedef struct {
        logic       wr;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl;
        logic [7:0] thr;
        logic       st;
        logic       sp;
        logic       v;
        logic       b;
        logic       e_out;
        logic [7:0] e_cnt;
        logic       e_irq;
        logic       e_busy;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic sp, input logic v, input logic b,
                       input logic eo, input logic [7:0] ec, input logic ei,
                       input logic eb, input logic ee);
        vec_t t;
        t = '{wr: 1'b0, pat: 8'h00, len: 4'd0, ovl: 1'b0, thr: 8'h00, st: st, sp: sp,
              v: v, b: b, e_out: eo, e_cnt: ec, e_irq: ei, e_busy: eb, e_err: ee};
        vecs.push_back(t);
    endtask

    task automatic add_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                           input logic [7:0] thr, input logic st, input logic [7:0] ec,
                           input logic eb, input logic ee);
        vec_t t;
        t = '{wr: 1'b1, pat: pat, len: len, ovl: ovl, thr: thr, st: st, sp: 1'b0,
              v: 1'b0, b: 1'b0, e_out: 1'b0, e_cnt: ec, e_irq: 1'b0, e_busy: eb, e_err: ee};
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        cfg_wr = 1'b0; cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;
        cfg_thresh = 8'h00; start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_seq = 1'b0;
    endtask

    task automatic bit_in(input logic b);
        @(negedge clk);
        drive_idle();
        in_valid = 1'b1;
        in_seq   = b;
    endtask

    // Watchdog so the run can never hang
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tests = 0;
        fails = 0;
        drive_idle();
        rst = 1'b1;

        // Default 10110, overlapping: matches on bits 5 and 8
        add(1,0,0,0, 0,8'd0,0,1,0);
        add(0,0,1,1, 0,8'd0,0,1,0);
        add(0,0,1,0, 0,8'd0,0,1,0);
        add(0,0,1,1, 0,8'd0,0,1,0);
        add(0,0,1,1, 0,8'd0,0,1,0);
        add(0,0,1,0, 1,8'd1,0,1,0);
        add(0,0,1,1, 0,8'd1,0,1,0);
        add(0,0,1,1, 0,8'd1,0,1,0);
        add(0,0,1,0, 1,8'd2,0,1,0);
        add(0,1,0,0, 0,8'd2,0,0,0);
        // Non-overlapping: only bit 5 matches
        add_cfg(8'h16, 4'd5, 1'b0, 8'd0, 1'b0, 8'd2, 1'b0, 1'b0);
        add(1,0,0,0, 0,8'd0,0,1,0);
        add(0,0,1,1, 0,8'd0,0,1,0);
        add(0,0,1,0, 0,8'd0,0,1,0);
        add(0,0,1,1, 0,8'd0,0,1,0);
        add(0,0,1,1, 0,8'd0,0,1,0);
        add(0,0,1,0, 1,8'd1,0,1,0);
        add(0,0,1,1, 0,8'd1,0,1,0);
        add(0,0,1,1, 0,8'd1,0,1,0);
        add(0,0,1,0, 0,8'd1,0,1,0);
        add(0,1,0,0, 0,8'd1,0,0,0);
        // Pattern 11, thresh 3, config written together with start
        add_cfg(8'h03, 4'd2, 1'b1, 8'd3, 1'b1, 8'd0, 1'b1, 1'b0);
        add(0,0,1,1, 0,8'd0,0,1,0);
        add(0,0,1,1, 1,8'd1,0,1,0);
        add(0,0,1,1, 1,8'd2,0,1,0);
        add(0,0,1,1, 1,8'd3,1,1,0);
        add(0,0,1,1, 0,8'd3,1,1,0);
        add(0,1,0,0, 0,8'd3,0,0,0);
        // start and stop together in IDLE: stop wins
        add(1,1,0,0, 0,8'd3,0,0,0);
        // Restore default, then rejected writes in RUN and with len 1
        add_cfg(8'h16, 4'd5, 1'b1, 8'd0, 1'b0, 8'd3, 1'b0, 1'b0);
        add(1,0,0,0, 0,8'd0,0,1,0);
        add_cfg(8'hFF, 4'd2, 1'b1, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1);
        add(0,0,0,0, 0,8'd0,0,1,0);
        add(0,1,0,0, 0,8'd0,0,0,0);
        add_cfg(8'h01, 4'd1, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1);
        add(0,0,0,0, 0,8'd0,0,0,0);
        add(1,0,0,0, 0,8'd0,0,1,0);
        add(0,0,1,1, 0,8'd0,0,1,0);
        add(0,0,1,0, 0,8'd0,0,1,0);
        add(0,0,1,1, 0,8'd0,0,1,0);
        add(0,0,1,1, 0,8'd0,0,1,0);
        add(0,0,1,0, 1,8'd1,0,1,0);
        // Restart, then 1,0,1 / 3 invalid cycles / 1,0
        add(1,0,0,0, 0,8'd0,0,1,0);
        add(0,0,1,1, 0,8'd0,0,1,0);
        add(0,0,1,0, 0,8'd0,0,1,0);
        add(0,0,1,1, 0,8'd0,0,1,0);
        add(0,0,0,1, 0,8'd0,0,1,0);
        add(0,0,0,0, 0,8'd0,0,1,0);
        add(0,0,0,1, 0,8'd0,0,1,0);
        add(0,0,1,1, 0,8'd0,0,1,0);
        add(0,0,1,0, 1,8'd1,0,1,0);

        // Reset values while rst is held
        #12;
        check("reset out", out, 1'b0);
        check("reset match_count", match_count, 8'd0);
        check("reset irq", irq, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset cfg_err", cfg_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            cfg_wr      = vecs[i].wr;
            cfg_pattern = vecs[i].pat;
            cfg_len     = vecs[i].len;
            cfg_overlap = vecs[i].ovl;
            cfg_thresh  = vecs[i].thr;
            start       = vecs[i].st;
            stop        = vecs[i].sp;
            in_valid    = vecs[i].v;
            in_seq      = vecs[i].b;
            #1;
            check($sformatf("v%0d out", i), out, vecs[i].e_out);
            @(posedge clk);
            #1;
            check($sformatf("v%0d match_count", i), match_count, vecs[i].e_cnt);
            check($sformatf("v%0d irq", i), irq, vecs[i].e_irq);
            check($sformatf("v%0d busy", i), busy, vecs[i].e_busy);
            check($sformatf("v%0d cfg_err", i), cfg_err, vecs[i].e_err);
        end

        // Mid-stream reset after 1,0,1,1: the following 0 must not match
        @(negedge clk);
        drive_idle();
        start = 1'b1;
        bit_in(1'b1);
        bit_in(1'b0);
        bit_in(1'b1);
        bit_in(1'b1);
        @(negedge clk);
        drive_idle();
        in_valid = 1'b1;
        in_seq   = 1'b0;
        #1;
        check("pre-reset out armed", out, 1'b1);
        rst = 1'b1;
        #1;
        check("mid-reset out", out, 1'b0);
        check("mid-reset match_count", match_count, 8'd0);
        check("mid-reset irq", irq, 1'b0);
        check("mid-reset busy", busy, 1'b0);
        check("mid-reset cfg_err", cfg_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        start = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset busy", busy, 1'b1);
        bit_in(1'b0);
        #1;
        check("post-reset out", out, 1'b0);
        @(posedge clk);
        #1;
        check("post-reset match_count", match_count, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
